hash_pingpong_buf: RTL
======================

HASH_PINGPONG_BUF -- requirements
Module: hash_pingpong_buf

Interface
REQ-001 Parameter WORDS, default 1344, 64-bit words per bank (4 rows x 1344 16-bit A elements).
REQ-002 Parameter AW, default 11, bank word-address width; WORDS SHALL be <= 2^AW.
REQ-003 Clock and reset: clk, rst_n; rst_n is asynchronous, active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle pulse; clears all state and begins a run.
REQ-007 num_blocks  input  16  banks to produce in this run; sampled on start; 0 means the run completes immediately.
REQ-008 in_data  input  64  XOF word from the SHAKE core.
REQ-009 in_valid  input  1  in_data is valid.
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 hash_ready  output  1  level; the read bank is full and readable (the consumer's HASH_ready).
REQ-012 blk_done  input  1  single-cycle pulse; the consumer has finished the read bank.
REQ-013 rd_addr  input  32  consumer word address into the read bank (the consumer's addr_HASH).
REQ-014 rd_data  output  64  read word (the consumer's bram_data_HASH).
REQ-015 run_done  output  1  level; all num_blocks banks produced and consumed.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 Storage: two banks of WORDS x 64 bits. Write and read ports are independent; write pointer wr_bank/wr_ptr, read pointer rd_bank. Per-bank flag full[1:0].
REQ-018 FSM states: IDLE, RUN, DONE. start moves any state to RUN; it clears full, wr_ptr, wr_bank, rd_bank, the produced and consumed counters, run_done and err.
REQ-019 in_ready = (state==RUN) && !full[wr_bank] && (produced < num_blocks); combinational, with no dependence on in_valid.
REQ-020 Accept: in_valid && in_ready at a clock edge writes in_data to bank wr_bank at wr_ptr and increments wr_ptr.
REQ-021 Bank-fill accept: the accept at wr_ptr==WORDS-1 additionally sets full[wr_bank]=1, resets wr_ptr to 0, toggles wr_bank and increments produced.
REQ-022 hash_ready = (state==RUN) && full[rd_bank]; it rises the cycle after the bank-fill accept.
REQ-023 blk_done with hash_ready=1 clears full[rd_bank], toggles rd_bank and increments consumed; hash_ready falls the next cycle unless the other bank is already full.
REQ-024 blk_done with hash_ready=0 SHALL be ignored for state and SHALL set err.
REQ-025 Same cycle: a bank-fill accept on one bank and blk_done on the other bank SHALL both take effect. The same bank cannot be in both, because in_ready=0 while the write bank is full.
REQ-026 rd_data is registered with 1-cycle latency: rd_data = bank[rd_bank][rd_addr] as sampled at the prior edge. The read SHALL use the bank selected before any same-edge rd_bank toggle.
REQ-027 rd_addr >= WORDS returns rd_data = 0 and SHALL NOT set err.
REQ-028 RUN moves to DONE when consumed==num_blocks; in DONE, in_ready=0, hash_ready=0, run_done=1.
REQ-029 start with num_blocks=0 SHALL move to DONE on the next cycle.
REQ-030 start in RUN aborts the run: all data is discarded, no hash_ready pulse is generated for the old run, and RUN restarts.
REQ-031 produced and consumed are 16 bits wide; consumed <= produced <= consumed+2 SHALL always hold.
REQ-032 in_valid while in_ready=0 SHALL NOT be an error; the word is held by the source.

Reset
REQ-033 On rst_n low: state=IDLE, full=0, wr_ptr=0, wr_bank=0, rd_bank=0, counters=0, rd_data=0, in_ready=0, hash_ready=0, run_done=0, err=0.
REQ-034 Memory contents are not reset; a bank is never reported readable before it is fully rewritten.
REQ-035 Reset assertion mid-run SHALL take effect immediately (asynchronous); after deassertion the block stays in IDLE until start.

Verification
REQ-036 Scenario: start, num_blocks=1; stream words k=0..1343 with data=k, in_valid held high -> hash_ready rises on the cycle after the 1344th accept. Reads at addresses 0, 5, 1343 return 0, 5, 1343 one cycle later. blk_done -> run_done=1, hash_ready=0.
REQ-037 Scenario: num_blocks=3; source streams continuously; consumer holds off blk_done -> after 2688 accepts in_ready=0. The first blk_done re-asserts in_ready the next cycle, and hash_ready stays 1 with bank 1 data (word0=1344).
REQ-038 Scenario: blk_done pulsed while hash_ready=0 -> err=1 and stays 1 until the next start; pointers are unchanged.
REQ-039 Scenario: bank-1 fill accept in the same cycle as blk_done for bank 0 -> full=2'b10, rd_bank=1, hash_ready=1 continuously, produced=2, consumed=1.
REQ-040 Scenario: rd_addr=1344 and rd_addr=32'hFFFFFFFF -> rd_data=0, err=0.
REQ-041 Scenario: start mid-fill at wr_ptr=700, then rst_n pulsed during a later fill -> all outputs take their reset values; a new start with num_blocks=1 requires a full 1344 accepts before hash_ready.

Source files
------------

// File: rtl/hash_pingpong_buf_if.sv
// Handshake and read-port bundle between the SHAKE XOF source, the ping-pong buffer
// and the hash consumer. The master modport drives the inputs; the buffer uses the slave modport.
interface hash_pingpong_buf_if;
  logic        start;
  logic [15:0] num_blocks;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        hash_ready;
  logic        blk_done;
  logic [31:0] rd_addr;
  logic [63:0] rd_data;
  logic        run_done;
  logic        err;

  modport master (
    output start, num_blocks, in_data, in_valid, blk_done, rd_addr,
    input  in_ready, hash_ready, rd_data, run_done, err
  );

  modport slave (
    input  start, num_blocks, in_data, in_valid, blk_done, rd_addr,
    output in_ready, hash_ready, rd_data, run_done, err
  );
endinterface

// File: rtl/hash_pingpong_buf.sv
// Two-bank ping-pong buffer: XOF words fill one bank while the consumer reads the other.
// A bank becomes readable only after all WORDS entries have been rewritten in the current run.
module hash_pingpong_buf #(
  parameter int WORDS = 1344,
  parameter int AW    = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  hash_pingpong_buf_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [1:0]    full_r;
  logic [1:0]    full_nxt_s;
  logic [AW-1:0] wr_ptr_r;
  logic          wr_bank_r;
  logic          rd_bank_r;
  logic [15:0]   produced_r;
  logic [15:0]   consumed_r;
  logic [15:0]   nblk_r;
  logic          err_r;
  logic [63:0]   rd_data_r;

  logic [63:0]   bank0_r [WORDS];
  logic [63:0]   bank1_r [WORDS];

  logic          run_s;
  logic          in_ready_s;
  logic          hash_ready_s;
  logic          accept_s;
  logic          last_s;
  logic          fill_s;
  logic          release_s;
  logic          rd_in_range_s;
  logic [AW-1:0] rd_idx_s;

  assign run_s         = (state_r == S_RUN);
  assign in_ready_s    = run_s && !full_r[wr_bank_r] && (produced_r < nblk_r);
  assign hash_ready_s  = run_s && full_r[rd_bank_r];
  assign accept_s      = bus.in_valid && in_ready_s;
  assign last_s        = (wr_ptr_r == AW'(WORDS - 1));
  assign fill_s        = accept_s && last_s;
  assign release_s     = bus.blk_done && hash_ready_s;
  assign rd_in_range_s = (bus.rd_addr < 32'(WORDS));
  assign rd_idx_s      = bus.rd_addr[AW-1:0];

  assign bus.in_ready   = in_ready_s;
  assign bus.hash_ready = hash_ready_s;
  assign bus.rd_data    = rd_data_r;
  assign bus.run_done   = (state_r == S_DONE);
  assign bus.err        = err_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; start overrides everything and (re)enters RUN.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.start) begin
      state_nxt_s = S_RUN;
    end else begin
      case (state_r)
        S_IDLE:  state_nxt_s = S_IDLE;
        S_RUN: begin
          if (consumed_r == nblk_r) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_RUN;
          end
        end
        S_DONE:  state_nxt_s = S_DONE;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Full flags: fill and release always target different banks, so both can apply.
  always_comb begin
    full_nxt_s = full_r;
    if (fill_s) begin
      full_nxt_s[wr_bank_r] = 1'b1;
    end else begin
      full_nxt_s = full_nxt_s;
    end
    if (release_s) begin
      full_nxt_s[rd_bank_r] = 1'b0;
    end else begin
      full_nxt_s = full_nxt_s;
    end
  end

  // Pointers, counters and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r     <= 2'b00;
      wr_ptr_r   <= '0;
      wr_bank_r  <= 1'b0;
      rd_bank_r  <= 1'b0;
      produced_r <= 16'd0;
      consumed_r <= 16'd0;
      nblk_r     <= 16'd0;
      err_r      <= 1'b0;
    end else if (bus.start) begin
      full_r     <= 2'b00;
      wr_ptr_r   <= '0;
      wr_bank_r  <= 1'b0;
      rd_bank_r  <= 1'b0;
      produced_r <= 16'd0;
      consumed_r <= 16'd0;
      nblk_r     <= bus.num_blocks;
      err_r      <= 1'b0;
    end else begin
      full_r <= full_nxt_s;
      if (fill_s) begin
        wr_ptr_r   <= '0;
        wr_bank_r  <= ~wr_bank_r;
        produced_r <= produced_r + 16'd1;
      end else if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (release_s) begin
        rd_bank_r  <= ~rd_bank_r;
        consumed_r <= consumed_r + 16'd1;
      end
      if (bus.blk_done && !hash_ready_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Bank write port; storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept_s && !bus.start) begin
      if (wr_bank_r) begin
        bank1_r[wr_ptr_r] <= bus.in_data;
      end else begin
        bank0_r[wr_ptr_r] <= bus.in_data;
      end
    end
  end

  // Registered read from the bank selected before any same-edge rd_bank toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= 64'd0;
    end else if (!rd_in_range_s) begin
      rd_data_r <= 64'd0;
    end else if (rd_bank_r) begin
      rd_data_r <= bank1_r[rd_idx_s];
    end else begin
      rd_data_r <= bank0_r[rd_idx_s];
    end
  end

endmodule
